ex_stall_ctrl: RTL and testbench
================================

# ex_stall_ctrl

Pipeline stall controller for the EX stage. It generates the global `delay` that freezes ID→EX→MEM registers, for three cases:
- a multi-cycle multiply sits on the ID→EX boundary;
- a load/store held in EXResult is waiting for memory;
- a memory-wait watchdog expires.

The block sits beside the EX stage. It observes the ID result header and the EX result header, and drives `delay` to every pipeline stage.

## Interface
- `MUL_LAT`, 3, cycles a multiply (opcode 0011 / 0110) needs in EX; legal range 1..15; 1 means no multiply stall.
- `MEM_TIMEOUT`, 16, maximum consecutive cycles stalled on one memory op before forced release; legal range 2..255.
- `clk` in 1: pipeline clock.
- `reset` in 1: asynchronous, active-high.
- `id_valid` in 1: IDResult valid bit (IDResult[105]).
- `id_opcode` in 4: IDResult opcode (IDResult[104:101]).
- `ex_valid` in 1: EXResult valid bit (EXResult[73]).
- `ex_opcode` in 4: EXResult opcode (EXResult[72:69]).
- `mem_ready` in 1: data memory has completed the access presented by EXResult this cycle.
- `err_clr` in 1: clears `mem_err`.
- `delay` out 1: global stall; combinational from inputs and state.
- `stall_state` out 2: registered cause of the stall: 00 IDLE, 01 MUL_WAIT, 10 MEM_WAIT.
- `mem_err` out 1: sticky; set when a memory-wait timeout has occurred.
- `perf_stall_cnt` out 32: only when the macro in Configuration is defined.

## Operation
- Derived signals:
  - `id_mul` = `id_valid` & (`id_opcode` == 0011 | 0110).
  - `ex_mem` = `ex_valid` & (`ex_opcode` == 1000 | 1001).
- Multiply wait:
  - `mul_pending` = `id_mul` & (`mul_cnt` != MUL_LAT-1).
  - `mul_cnt` (4 b) at posedge: if `delay` & `id_mul` then `mul_cnt`+1, saturating at MUL_LAT-1; else 0.
- Memory wait:
  - `mem_pending` = `ex_mem` & !`mem_done` & !`mem_ready`.
  - `mem_done` at posedge: cleared when `delay`=0 (pipeline advances). Otherwise set when `ex_mem` & `mem_ready`, or on a timeout. This prevents a completed access from being re-waited while a multiply stall holds EXResult.
- Watchdog:
  - `wd_cnt` (8 b) at posedge: `wd_cnt`+1 while `mem_pending`, else 0.
  - Timeout event = `mem_pending` & (`wd_cnt` == MEM_TIMEOUT-1). On it, at posedge: `mem_done`←1 and `mem_err`←1.
- `delay` = `mem_pending` | `mul_pending`. Multiply and memory waits overlap; the stall length is the maximum of the two, not the sum.
- `stall_state` at posedge:
  - 10 if `mem_pending`;
  - else 01 if `mul_pending`;
  - else 00.
  - MEM_WAIT has priority over MUL_WAIT.
- `mem_err` at posedge:
  - `err_clr` clears it.
  - A timeout event in the same cycle wins (set).

## Timing
- Reset (async) values:
  - `mul_cnt`, `wd_cnt`, `mem_done`, `mem_err` = 0;
  - `stall_state` = 00;
  - `perf_stall_cnt` = 0.
  - `delay` is 0 while `reset` is high.
- Multiply entering ID output at cycle 0:
  - `delay`=1 for cycles 0..MUL_LAT-2 and 0 in cycle MUL_LAT-1.
  - EX latches at the posedge ending cycle MUL_LAT-1.
  - MUL_LAT=1 gives zero stall.
- Back-to-back multiplies: `mul_cnt` returns to 0 on the advancing edge, so each multiply stalls MUL_LAT-1 cycles.
- Memory op:
  - `delay` drops in the same cycle `mem_ready` is high (zero-latency release).
  - Maximum stall per op is MEM_TIMEOUT cycles.
- Reset mid-stall: all state clears immediately; no partial count survives.
- `err_clr` & `reset` together: reset dominates.

## Configuration
- `EX_STALL_CTRL_PERF_EN`:
  - Defined: `perf_stall_cnt` port exists. It counts posedges at which `delay`=1, saturates at 32'hFFFFFFFF, and is cleared only by reset.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- MUL_LAT=3, `id_valid`=1, `id_opcode`=0011 held, no mem op → `delay`=1,1,0 over three cycles; `stall_state` reads 01,01,00 on the following edges.
- `ex_valid`=1, `ex_opcode`=1000, `mem_ready` low 4 cycles then high → `delay` high 4 cycles, low in the ready cycle; `mem_err`=0.
- Load in EX with `mem_ready` held low, MEM_TIMEOUT=16 → `delay` high exactly 16 cycles, then 0; `mem_err`=1 until `err_clr` pulse, then 0.
- Multiply in ID (MUL_LAT=4) plus store in EX with `mem_ready` high in cycle 1 → `delay` high cycles 0..2, low cycle 3; no re-wait on the store after cycle 1 (`mem_done`=1).
- Reset asserted mid multiply stall (`mul_cnt`=1) → `delay`=0 asynchronously; after release the same multiply stalls the full MUL_LAT-1 cycles.
- `EX_STALL_CTRL_PERF_EN` defined, run the 16-cycle timeout scenario → `perf_stall_cnt`=16.

Source files
------------

// File: rtl/ex_stall_ctrl.sv
// ---------------------------------------------------------------------------
// ex_stall_ctrl
//
// Stall controller for the EX stage. Produces the global pipeline stall
// `delay` that freezes the ID->EX->MEM registers. There are three causes:
//   - a multi-cycle multiply waiting on the ID->EX boundary,
//   - a load/store held in EXResult waiting for data memory,
//   - a memory-wait watchdog that forces release of a hung memory access.
//
// Optional feature macro: EX_STALL_CTRL_PERF_EN
//   When defined, a 32-bit saturating stall-cycle counter is added and
//   exported on perf_stall_cnt.
//
// Parameters:
//   MUL_LAT      multiply latency in EX, 1..15 (1 = multiply never stalls)
//   MEM_TIMEOUT  max consecutive stall cycles on one memory op, 2..255
//
// Ports:
//   clk            pipeline clock
//   reset          asynchronous active-high reset
//   id_valid       IDResult valid bit
//   id_opcode      IDResult opcode
//   ex_valid       EXResult valid bit
//   ex_opcode      EXResult opcode
//   mem_ready      data memory completed the EXResult access this cycle
//   err_clr        clears the sticky mem_err flag
//   delay          global stall (combinational)
//   stall_state    registered stall cause: 00 IDLE, 01 MUL_WAIT, 10 MEM_WAIT
//   mem_err        sticky flag, set when the memory watchdog fires
//   perf_stall_cnt count of stalled clock edges (only with the macro)
// ---------------------------------------------------------------------------
module ex_stall_ctrl #(
  parameter int MUL_LAT     = 3,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [3:0]  id_opcode,
  input  logic        ex_valid,
  input  logic [3:0]  ex_opcode,
  input  logic        mem_ready,
  input  logic        err_clr,
  output logic        delay,
`ifdef EX_STALL_CTRL_PERF_EN
  output logic [31:0] perf_stall_cnt,
`endif
  output logic [1:0]  stall_state,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MUL_WAIT = 2'b01,
    MEM_WAIT = 2'b10
  } stallState_t;

  localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);
  localparam logic [7:0] WD_LAST  = 8'(MEM_TIMEOUT - 1);

  logic [3:0]  mulCnt;
  logic [7:0]  wdCnt;
  logic        memDone;
  stallState_t stateQ;

  logic idMul;
  logic exMem;
  logic mulPending;
  logic memPending;
  logic timeout;

  // Decode the two headers and work out which waits are outstanding.
  // The multiply is done once mulCnt has reached MUL_LAT-1, so MUL_LAT=1
  // never stalls. A memory op stops stalling either when memory answers
  // this cycle or once it has already completed (or timed out) while
  // something else held the pipeline.
  always_comb begin
    idMul      = id_valid && (id_opcode == 4'b0011 || id_opcode == 4'b0110);
    exMem      = ex_valid && (ex_opcode == 4'b1000 || ex_opcode == 4'b1001);
    mulPending = idMul && (mulCnt != MUL_LAST);
    memPending = exMem && !memDone && !mem_ready;
    timeout    = memPending && (wdCnt == WD_LAST);
  end

  // Both waits overlap, so the stall length is the longer of the two.
  // Reset forces the stall low even though the input decode is still live.
  assign delay = !reset && (memPending || mulPending);

  assign stall_state = stateQ;

  // Multiply latency counter: counts stalled cycles of the multiply in ID
  // and drops back to zero on the edge where the pipeline advances, so a
  // following multiply gets its own full latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mulCnt <= 4'd0;
    end else if (delay && idMul) begin
      if (mulCnt != MUL_LAST) begin
        mulCnt <= mulCnt + 4'd1;
      end
    end else begin
      mulCnt <= 4'd0;
    end
  end

  // Remembers that the memory op in EXResult is finished while the
  // pipeline is still frozen (e.g. by a multiply), so it is not waited on
  // a second time. Cleared whenever the pipeline advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memDone <= 1'b0;
    end else if (!delay) begin
      memDone <= 1'b0;
    end else if ((exMem && mem_ready) || timeout) begin
      memDone <= 1'b1;
    end
  end

  // Watchdog: counts consecutive cycles spent waiting on memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdCnt <= 8'd0;
    end else if (memPending) begin
      wdCnt <= wdCnt + 8'd1;
    end else begin
      wdCnt <= 8'd0;
    end
  end

  // Registered stall cause; a memory wait is reported ahead of a multiply.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= IDLE;
    end else if (memPending) begin
      stateQ <= MEM_WAIT;
    end else if (mulPending) begin
      stateQ <= MUL_WAIT;
    end else begin
      stateQ <= IDLE;
    end
  end

  // Sticky timeout flag. A timeout in the same cycle as err_clr wins so
  // that a fresh error is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_err <= 1'b0;
    end else if (timeout) begin
      mem_err <= 1'b1;
    end else if (err_clr) begin
      mem_err <= 1'b0;
    end
  end

`ifdef EX_STALL_CTRL_PERF_EN
  // Saturating count of clock edges at which the pipeline was stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt <= 32'd0;
    end else if (delay && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ex_stall_ctrl
//
// Directed testbench for ex_stall_ctrl. Two instances share the same
// stimulus: dutA uses MUL_LAT=3, dutB uses MUL_LAT=4; both MEM_TIMEOUT=16.
// Inputs change 1 ns after the rising edge; delay is sampled on the falling
// edge and registered outputs 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_ex_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [3:0] id_opcode;
  logic       ex_valid;
  logic [3:0] ex_opcode;
  logic       mem_ready;
  logic       err_clr;

  logic       delayA, delayB;
  logic [1:0] stateA, stateB;
  logic       errA, errB;
`ifdef EX_STALL_CTRL_PERF_EN
  logic [31:0] perfA, perfB;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ex_stall_ctrl #(.MUL_LAT(3), .MEM_TIMEOUT(16)) dutA (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_opcode(id_opcode),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .mem_ready(mem_ready), .err_clr(err_clr),
    .delay(delayA),
`ifdef EX_STALL_CTRL_PERF_EN
    .perf_stall_cnt(perfA),
`endif
    .stall_state(stateA), .mem_err(errA)
  );

  ex_stall_ctrl #(.MUL_LAT(4), .MEM_TIMEOUT(16)) dutB (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_opcode(id_opcode),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .mem_ready(mem_ready), .err_clr(err_clr),
    .delay(delayB),
`ifdef EX_STALL_CTRL_PERF_EN
    .perf_stall_cnt(perfB),
`endif
    .stall_state(stateB), .mem_err(errB)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    id_valid  = 1'b0;
    id_opcode = 4'b0000;
    ex_valid  = 1'b0;
    ex_opcode = 4'b0000;
    mem_ready = 1'b0;
    err_clr   = 1'b0;
  endtask

  // Reset values; a pending load during reset must not raise delay.
  task automatic test_reset();
    reset     = 1'b1;
    ex_valid  = 1'b1;
    ex_opcode = 4'b1000;
    err_clr   = 1'b1;
    step();
    step();
    compared++;
    if (delayA !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_delay: got %b want 0", delayA);
    end
    compared++;
    if (stateA !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL reset_state: got %b want 00", stateA);
    end
    compared++;
    if (errA !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_err: got %b want 0", errA);
    end
`ifdef EX_STALL_CTRL_PERF_EN
    compared++;
    if (perfA !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_perf: got %0d want 0", perfA);
    end
`endif
    idleInputs();
    reset = 1'b0;
    step();
  endtask

  // Non-matching headers never stall.
  task automatic test_decode();
    logic       vldTab [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] idTab  [4] = '{4'b0011, 4'b0111, 4'b0000, 4'b0110};
    logic [3:0] exTab  [4] = '{4'b1000, 4'b0000, 4'b1010, 4'b1001};
    for (int i = 0; i < 4; i++) begin
      id_valid  = vldTab[i];
      id_opcode = idTab[i];
      ex_valid  = vldTab[i];
      ex_opcode = exTab[i];
      @(negedge clk);
      compared++;
      if (delayA !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL decode_%0d delay: got %b want 0", i, delayA);
      end
      step();
    end
    idleInputs();
    step();
  endtask

  // MUL_LAT=3 multiply held in ID: two back-to-back multiplies, each
  // stalling two cycles.
  task automatic test_mul_back_to_back();
    logic       expD [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0] expS [6] = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
    id_valid  = 1'b1;
    id_opcode = 4'b0011;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) id_opcode = 4'b0110;
      @(negedge clk);
      compared++;
      if (delayA !== expD[i]) begin
        mismatched++;
        $display("[TB] FAIL mul_c%0d delay: got %b want %b", i, delayA, expD[i]);
      end
      step();
      compared++;
      if (stateA !== expS[i]) begin
        mismatched++;
        $display("[TB] FAIL mul_c%0d state: got %b want %b", i, stateA, expS[i]);
      end
    end
    idleInputs();
    step();
  endtask

  // Load waits four cycles, then releases in the ready cycle.
  task automatic test_mem_wait();
    ex_valid  = 1'b1;
    ex_opcode = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i == 4);
      @(negedge clk);
      compared++;
      if (delayA !== (i < 4)) begin
        mismatched++;
        $display("[TB] FAIL mem_c%0d delay: got %b want %b", i, delayA, (i < 4));
      end
      step();
      compared++;
      if (stateA !== ((i < 4) ? 2'b10 : 2'b00)) begin
        mismatched++;
        $display("[TB] FAIL mem_c%0d state: got %b want %b", i, stateA,
                 ((i < 4) ? 2'b10 : 2'b00));
      end
    end
    compared++;
    if (errA !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mem_err: got %b want 0", errA);
    end
    idleInputs();
    step();
  endtask

  // Hung store: exactly 16 stalled cycles, sticky error, cleared by err_clr.
  task automatic test_timeout();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step();
    ex_valid  = 1'b1;
    ex_opcode = 4'b1001;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      compared++;
      if (delayA !== (i < 16)) begin
        mismatched++;
        $display("[TB] FAIL to_c%0d delay: got %b want %b", i, delayA, (i < 16));
      end
      step();
    end
    idleInputs();
    compared++;
    if (errA !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL to_err_set: got %b want 1", errA);
    end
`ifdef EX_STALL_CTRL_PERF_EN
    compared++;
    if (perfA !== 32'd16) begin
      mismatched++;
      $display("[TB] FAIL to_perf: got %0d want 16", perfA);
    end
`endif
    step();
    compared++;
    if (errA !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL to_err_sticky: got %b want 1", errA);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    compared++;
    if (errA !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL to_err_clr: got %b want 0", errA);
    end
    step();
  endtask

  // MUL_LAT=4 multiply plus store answered in cycle 1: stall is the
  // multiply's three cycles, and the store is not re-waited.
  task automatic test_mul_mem_overlap();
    logic       expD [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] expS [4] = '{2'b10, 2'b01, 2'b01, 2'b00};
    id_valid  = 1'b1;
    id_opcode = 4'b0011;
    ex_valid  = 1'b1;
    ex_opcode = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 1);
      @(negedge clk);
      compared++;
      if (delayB !== expD[i]) begin
        mismatched++;
        $display("[TB] FAIL ovl_c%0d delay: got %b want %b", i, delayB, expD[i]);
      end
      step();
      compared++;
      if (stateB !== expS[i]) begin
        mismatched++;
        $display("[TB] FAIL ovl_c%0d state: got %b want %b", i, stateB, expS[i]);
      end
    end
    idleInputs();
    step();
  endtask

  // Reset in the middle of a multiply stall; afterwards the same multiply
  // stalls its full two cycles again.
  task automatic test_reset_mid_stall();
    id_valid  = 1'b1;
    id_opcode = 4'b0110;
    step();
    #2;
    reset = 1'b1;
    #1;
    compared++;
    if (delayA !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rst_mid delay: got %b want 0", delayA);
    end
    compared++;
    if (stateA !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL rst_mid state: got %b want 00", stateA);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if (delayA !== (i < 2)) begin
        mismatched++;
        $display("[TB] FAIL rst_c%0d delay: got %b want %b", i, delayA, (i < 2));
      end
      step();
    end
    idleInputs();
    step();
  endtask

  initial begin
    idleInputs();
    reset = 1'b1;
    test_reset();
    test_decode();
    test_mul_back_to_back();
    test_mem_wait();
    test_timeout();
    test_mul_mem_overlap();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
